// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction-fetch controller.
//   RESET_PC / INT_VEC / EXC_VEC : fixed entry addresses (kseg, bit 31 set)
//   ROM_WORDS                    : implemented instruction ROM depth in words
//   BOOT / RUN / TRAP            : fetch FSM state encodings
//   pc_plus4()                   : sequential PC step, wraps inside the PC[31] segment
package fetch_pkg;

   localparam logic [31:0] RESET_PC  = 32'h8000_0000;
   localparam logic [31:0] INT_VEC   = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
   localparam int unsigned ROM_WORDS = 128;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t BOOT = 2'd0;
   localparam fetch_state_t RUN  = 2'd1;
   localparam fetch_state_t TRAP = 2'd2;

   // Bit 31 (kernel segment) never carries out of the low 31 bits.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      logic [30:0] low;
      low = pc[30:0] + 31'd4;
      return {pc[31], low};
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC priority mux for if_fetch_ctrl.
//   in : state, pc, epc, stall, redirect_valid, redirect_pc, irq, exc, exc_pc
//   out: pc_next, epc_next, capture (load ROM word into IF/ID),
//        bubble (load empty slot into IF/ID), trap (enter TRAP state)
// Neither capture nor bubble means IF/ID holds (stall, BOOT).
// Optional macro FETCH_BOUND_CHECK_EN: a sequential fetch beyond the ROM
// raises an internal exception instead of fetching zeros.
import fetch_pkg::*;

module next_pc_sel (
   input  logic [1:0]  state,
   input  logic [31:0] pc,
   input  logic [31:0] epc,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        irq,
   input  logic        exc,
   input  logic [31:0] exc_pc,
   output logic [31:0] pc_next,
   output logic [31:0] epc_next,
   output logic        capture,
   output logic        bubble,
   output logic        trap
);

   logic fetch_oob;

`ifdef FETCH_BOUND_CHECK_EN
   assign fetch_oob = ({3'b000, pc[30:2]} >= ROM_WORDS);
`else
   assign fetch_oob = 1'b0;
`endif

   always_comb begin
      pc_next  = pc;
      epc_next = epc;
      capture  = 1'b0;
      bubble   = 1'b0;
      trap     = 1'b0;
      case (state)
         BOOT: begin
            pc_next = RESET_PC;
         end
         TRAP: begin
            // The vector word presented now is discarded; PC holds so it is
            // fetched again once back in RUN. Interrupts are not sampled here.
            bubble = 1'b1;
            if (exc) begin
               pc_next  = EXC_VEC;
               epc_next = exc_pc;
               trap     = 1'b1;
            end
         end
         default: begin
            if (exc) begin
               pc_next  = EXC_VEC;
               epc_next = exc_pc;
               bubble   = 1'b1;
               trap     = 1'b1;
            end else if (irq && !pc[31]) begin
               pc_next  = INT_VEC;
               // A pending redirect means the current PC is already dead.
               epc_next = redirect_valid ? redirect_pc : pc;
               bubble   = 1'b1;
               trap     = 1'b1;
            end else if (redirect_valid) begin
               pc_next = redirect_pc;
               bubble  = 1'b1;
            end else if (stall) begin
               pc_next = pc;
            end else if (fetch_oob) begin
               pc_next  = EXC_VEC;
               epc_next = pc;
               bubble   = 1'b1;
               trap     = 1'b1;
            end else begin
               pc_next = pc_plus4(pc);
               capture = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch controller for the pipelined MIPS core.
// Owns the PC, addresses the instruction ROM, fills the IF/ID register and
// records EPC on traps.
//   clk, reset (sync, active-high)
//   stall, redirect_valid/redirect_pc, irq, exc/exc_pc : next-PC requests
//   rom_addr (= PC, combinational), rom_data           : ROM port
//   if_instr, if_pc4, if_valid                          : IF/ID register
//   epc, kernel (= PC[31])                              : trap state
// Optional macro FETCH_BOUND_CHECK_EN: trap on sequential fetch past ROM_WORDS.
import fetch_pkg::*;

module if_fetch_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        irq,
   input  logic        exc,
   input  logic [31:0] exc_pc,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc4,
   output logic        if_valid,
   output logic [31:0] epc,
   output logic        kernel
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q;
   logic [31:0]  pc_next, epc_next;
   logic         capture, bubble, trap;

   next_pc_sel u_next_pc_sel (
      .state          (state_q),
      .pc             (pc_q),
      .epc            (epc),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .irq            (irq),
      .exc            (exc),
      .exc_pc         (exc_pc),
      .pc_next        (pc_next),
      .epc_next       (epc_next),
      .capture        (capture),
      .bubble         (bubble),
      .trap           (trap)
   );

   always_comb begin
      state_d = RUN;
      if (state_q != BOOT && trap) begin
         state_d = TRAP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         epc      <= 32'h0;
         if_instr <= 32'h0;
         if_pc4   <= 32'h0;
         if_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_next;
         epc     <= epc_next;
         if (capture) begin
            if_instr <= rom_data;
            if_pc4   <= pc_plus4(pc_q);
            if_valid <= 1'b1;
         end else if (bubble) begin
            // if_pc4 is meaningless without if_valid and is left as is.
            if_instr <= 32'h0;
            if_valid <= 1'b0;
         end
      end
   end

   assign rom_addr = pc_q;
   assign kernel   = pc_q[31];

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, redirect_valid, irq, exc;
   logic [31:0] redirect_pc, exc_pc;
   logic [31:0] rom_addr, rom_data;
   logic [31:0] if_instr, if_pc4, epc;
   logic        if_valid, kernel;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] instr;
      logic        chk4;
      logic [31:0] pc4;
      logic [31:0] epc;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   if_fetch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .irq            (irq),
      .exc            (exc),
      .exc_pc         (exc_pc),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .if_instr       (if_instr),
      .if_pc4         (if_pc4),
      .if_valid       (if_valid),
      .epc            (epc),
      .kernel         (kernel)
   );

   // ROM model: word 0 is the boot jump, others a recognisable pattern,
   // words past the implemented depth read as zero.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [28:0] idx;
      idx = a[30:2];
      if (idx >= 29'd128) return 32'h0;
      if (idx == 29'd0) return 32'h0800_0003;
      return 32'h2400_0000 | {3'b000, idx};
   endfunction

   assign rom_data = rom_word(rom_addr);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic rs, input logic st, input logic rv,
                         input logic [31:0] rpc, input logic iq, input logic ex,
                         input logic [31:0] xpc);
      reset          = rs;
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      irq            = iq;
      exc            = ex;
      exc_pc         = xpc;
   endtask

   // Push the expectation for this cycle, clock once, pop and compare.
   task automatic go(input string tag, input logic [31:0] pc, input logic valid,
                     input logic [31:0] instr, input logic chk4, input logic [31:0] pc4,
                     input logic [31:0] e_epc);
      exp_t e;
      e.pc    = pc;
      e.valid = valid;
      e.instr = instr;
      e.chk4  = chk4;
      e.pc4   = pc4;
      e.epc   = e_epc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq({tag, ".pc"}, rom_addr, e.pc);
      check_eq({tag, ".valid"}, {31'b0, if_valid}, {31'b0, e.valid});
      check_eq({tag, ".instr"}, if_instr, e.instr);
      if (e.chk4) check_eq({tag, ".pc4"}, if_pc4, e.pc4);
      check_eq({tag, ".epc"}, epc, e.epc);
      check_eq({tag, ".kernel"}, {31'b0, kernel}, {31'b0, e.pc[31]});
   endtask

   initial begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      go("rst0", 32'h8000_0000, 0, 0, 1, 32'h0, 32'h0);
      go("rst1", 32'h8000_0000, 0, 0, 1, 32'h0, 32'h0);

      // Boot and free run
      set_in(0, 0, 0, 0, 0, 0, 0);
      go("boot", 32'h8000_0000, 0, 0, 1, 32'h0, 32'h0);
      go("run0", 32'h8000_0004, 1, 32'h0800_0003, 1, 32'h8000_0004, 32'h0);
      go("run1", 32'h8000_0008, 1, 32'h2400_0001, 1, 32'h8000_0008, 32'h0);
      go("run2", 32'h8000_000C, 1, 32'h2400_0002, 1, 32'h8000_000C, 32'h0);
      go("run3", 32'h8000_0010, 1, 32'h2400_0003, 1, 32'h8000_0010, 32'h0);

      // Stall holds, redirect overrides stall
      set_in(0, 1, 0, 0, 0, 0, 0);
      go("stall", 32'h8000_0010, 1, 32'h2400_0003, 1, 32'h8000_0010, 32'h0);
      set_in(0, 1, 1, 32'h0000_0074, 0, 0, 0);
      go("redir", 32'h0000_0074, 0, 0, 0, 0, 32'h0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      go("after_redir", 32'h0000_0078, 1, 32'h2400_001D, 1, 32'h0000_0078, 32'h0);

      // User-mode interrupt, irq held through TRAP and kernel mode
      set_in(0, 0, 1, 32'h0000_0040, 0, 0, 0);
      go("to40", 32'h0000_0040, 0, 0, 0, 0, 32'h0);
      set_in(0, 0, 0, 0, 1, 0, 0);
      go("irq", 32'h8000_0004, 0, 0, 0, 0, 32'h0000_0040);
      go("irq_trap", 32'h8000_0004, 0, 0, 0, 0, 32'h0000_0040);
      go("irq_vec", 32'h8000_0008, 1, 32'h2400_0001, 1, 32'h8000_0008, 32'h0000_0040);
      go("irq_masked", 32'h8000_000C, 1, 32'h2400_0002, 1, 32'h8000_000C, 32'h0000_0040);

      // Interrupt with a coincident redirect saves the redirect target
      set_in(0, 0, 1, 32'h0000_0100, 0, 0, 0);
      go("to100", 32'h0000_0100, 0, 0, 0, 0, 32'h0000_0040);
      set_in(0, 0, 1, 32'h0000_0120, 1, 0, 0);
      go("irq_rd", 32'h8000_0004, 0, 0, 0, 0, 32'h0000_0120);
      set_in(0, 0, 0, 0, 0, 0, 0);
      go("irq_rd_trap", 32'h8000_0004, 0, 0, 0, 0, 32'h0000_0120);
      go("irq_rd_vec", 32'h8000_0008, 1, 32'h2400_0001, 1, 32'h8000_0008, 32'h0000_0120);

      // exc beats irq and redirect; exc honoured again inside TRAP
      set_in(0, 0, 1, 32'h0000_0050, 0, 0, 0);
      go("to50", 32'h0000_0050, 0, 0, 0, 0, 32'h0000_0120);
      set_in(0, 1, 1, 32'h0000_0074, 1, 1, 32'h0000_0030);
      go("exc", 32'h8000_0008, 0, 0, 0, 0, 32'h0000_0030);
      set_in(0, 0, 0, 0, 0, 1, 32'h0000_0034);
      go("exc_in_trap", 32'h8000_0008, 0, 0, 0, 0, 32'h0000_0034);
      set_in(0, 0, 0, 0, 0, 0, 0);
      go("exc_trap", 32'h8000_0008, 0, 0, 0, 0, 32'h0000_0034);
      go("exc_vec", 32'h8000_000C, 1, 32'h2400_0002, 1, 32'h8000_000C, 32'h0000_0034);

      // ROM boundary
      set_in(0, 0, 1, 32'h0000_01FC, 0, 0, 0);
      go("to1fc", 32'h0000_01FC, 0, 0, 0, 0, 32'h0000_0034);
      set_in(0, 0, 0, 0, 0, 0, 0);
      go("last_word", 32'h0000_0200, 1, 32'h2400_007F, 1, 32'h0000_0200, 32'h0000_0034);
`ifdef FETCH_BOUND_CHECK_EN
      go("oob_trap", 32'h8000_0008, 0, 0, 0, 0, 32'h0000_0200);
      go("oob_trap2", 32'h8000_0008, 0, 0, 0, 0, 32'h0000_0200);
`else
      go("oob0", 32'h0000_0204, 1, 32'h0, 1, 32'h0000_0204, 32'h0000_0034);
      go("oob1", 32'h0000_0208, 1, 32'h0, 1, 32'h0000_0208, 32'h0000_0034);
`endif

      // Reset during stall
      set_in(1, 1, 0, 0, 0, 0, 0);
      go("rst_stall", 32'h8000_0000, 0, 0, 1, 32'h0, 32'h0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      go("boot2", 32'h8000_0000, 0, 0, 1, 32'h0, 32'h0);
      go("run2_0", 32'h8000_0004, 1, 32'h0800_0003, 1, 32'h8000_0004, 32'h0);

      // Reset during TRAP
      set_in(0, 0, 1, 32'h0000_0010, 0, 0, 0);
      go("to10", 32'h0000_0010, 0, 0, 0, 0, 32'h0);
      set_in(0, 0, 0, 0, 1, 0, 0);
      go("irq2", 32'h8000_0004, 0, 0, 0, 0, 32'h0000_0010);
      set_in(1, 0, 0, 0, 1, 0, 0);
      go("rst_trap", 32'h8000_0000, 0, 0, 1, 32'h0, 32'h0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      go("boot3", 32'h8000_0000, 0, 0, 1, 32'h0, 32'h0);
      go("run3_0", 32'h8000_0004, 1, 32'h0800_0003, 1, 32'h8000_0004, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller for the pipelined MIPS core. It owns the program counter and drives the address port of the 128-word instruction ROM. It captures the returned word into the IF/ID register and arbitrates among the next-PC sources: sequential, branch/jump redirect, interrupt vector, exception vector and stall hold. It also records EPC and tracks the kernel bit (PC[31]) used to mask nested interrupts.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded by reset; vector of `j Main`
- INT_VEC, 32'h8000_0004, interrupt entry address
- EXC_VEC, 32'h8000_0008, exception entry address
- ROM_WORDS, 128, implemented ROM depth in words
- clk  in  1  system clock; everything rising-edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC and IF/ID (load-use hazard)
- redirect_valid  in  1  branch/jump/jr resolved in ID/EX
- redirect_pc  in  32  target of redirect
- irq  in  1  level interrupt request from timer/peripheral
- exc  in  1  one-cycle exception pulse from a later stage
- exc_pc  in  32  PC of the faulting instruction
- rom_addr  out  32  combinational copy of PC to ROM Address
- rom_data  in  32  ROM Instruction (combinational read)
- if_instr  out  32  IF/ID instruction register
- if_pc4  out  32  IF/ID PC+4 register (link value for jal)
- if_valid  out  1  IF/ID holds a real instruction
- epc  out  32  return address for trap handlers
- kernel  out  1  equals PC[31]

## Operation
- FSM states: BOOT, RUN, TRAP.
- BOOT is entered on reset. PC=RESET_PC. IF/ID is cleared (if_instr=0, if_pc4=0, if_valid=0). epc=0. BOOT moves to RUN after one cycle with no fetch captured.
- In RUN, next-PC priority is highest first:
  1. exc: PC=EXC_VEC, epc=exc_pc.
  2. irq && !kernel: PC=INT_VEC. epc=redirect_pc if redirect_valid, else the current PC (the squashed instruction is re-executed).
  3. redirect_valid: PC=redirect_pc.
  4. stall: PC and IF/ID hold.
  5. Otherwise: PC=PC+4 (31-bit wrap within the PC[31] segment; PC[31] is preserved).
- Cases 1–3 load a bubble into IF/ID (if_valid=0, if_instr=0). Case 5 loads if_instr=rom_data, if_pc4=PC+4, if_valid=1.
- Cases 1 and 2 enter TRAP. TRAP inserts one further bubble, then returns to RUN. irq is ignored in TRAP. exc is still honoured in TRAP.
- Redirect overrides stall: a stalled instruction behind a taken branch is dead.
- kernel is cleared only by a redirect whose target has bit 31 = 0 (jr $ra/$k0 return). Trap vectors set it.
- rom_addr = PC at all times. It is never gated.

## Timing
- Fetch latency is 1 cycle: the word at PC is in if_instr on the edge after PC is presented.
- Redirect penalty is 1 bubble.
- Trap penalty is 2 bubbles (capture cycle + TRAP).
- First valid instruction after reset deasserts: if_valid=1 on the 2nd edge (BOOT, then RUN capture of RESET_PC).
- reset mid-trap or mid-stall wins unconditionally and returns to BOOT.
- All outputs are registered except rom_addr.

## Configuration
- FETCH_BOUND_CHECK_EN:
  - Defined: a sequential fetch with PC[30:2] ≥ ROM_WORDS is treated as an internal exception. PC=EXC_VEC, epc=PC, TRAP.
  - Undefined: out-of-range fetch is not checked. The ROM returns 0, which executes as nop, and PC keeps incrementing.

## Structure
- Package `fetch_pkg` holds RESET_PC/INT_VEC/EXC_VEC defaults and the state enum (BOOT, RUN, TRAP).
- One sub-module: `next_pc_sel`, the combinational priority mux producing next PC, next epc and bubble flag. The FSM and registers stay in the top module.

## Test plan
- Reset, then release with rom_data=32'h0800_0003: if_valid 0,0,1; if_instr=32'h0800_0003, if_pc4=32'h8000_0004.
- Free run 4 cycles from RESET_PC with no stall/redirect: rom_addr steps 8000_0000, 8000_0004, 8000_0008, 8000_000C.
- redirect_valid with redirect_pc=32'h0000_0074 while stall=1: PC=0000_0074, one bubble, kernel→0.
- Interrupt in user mode: irq=1, kernel=0, PC=0000_0040 → PC=8000_0004, epc=0000_0040, two bubbles. irq held in TRAP and kernel mode causes no re-entry.
- exc pulse coincident with irq and redirect, exc_pc=0000_0030: exc wins, PC=8000_0008, epc=0000_0030.
- With FETCH_BOUND_CHECK_EN defined, sequential fetch reaching PC=0000_0200: trap to 8000_0008 with epc=0000_0200. Without the macro, rom_addr=0000_0200 and if_instr=0.
